vga_tile_renderer: RTL and testbench

Parametrised successor to the fixed 640x480 VGA controller and glyph painter. Generates VGA timing from a configurable pixel-clock divider and porch/sync parameters. Renders a full-screen tile map: each tile is a TILE_W x TILE_H glyph with a per-tile foreground colour. Fetches tile-map and glyph-row words from a shared synchronous RAM through a prefetch pipeline, and drives registered sync, blank and 8-bit RGB to the DAC pins.

---
 rtl/vga_tile_renderer.sv | 190 +++++++++++++++++++
 tb/tb_vga_tile_renderer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_renderer.sv
// VGA timing generator and tile-map renderer with a RAM prefetch pipeline feeding a glyph shift register.
// Optional feature macro: CURSOR_EN (blinking inverted tile cursor driven by cursor_col/cursor_row).
module vga_tile_renderer #(
  parameter int                PIX_DIV    = 2,
  parameter int                H_VIS      = 640,
  parameter int                H_FP       = 16,
  parameter int                H_SYNC     = 96,
  parameter int                H_BP       = 48,
  parameter int                V_VIS      = 480,
  parameter int                V_FP       = 10,
  parameter int                V_SYNC     = 2,
  parameter int                V_BP       = 33,
  parameter int                TILE_W     = 8,
  parameter int                TILE_H     = 8,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] MAP_BASE   = ADDR_W'(16'h0100),
  parameter logic [ADDR_W-1:0] GLYPH_BASE = ADDR_W'(16'h2000),
  parameter logic [7:0]        BG_COLOR   = 8'h00
) (
  input  logic              clk,
  input  logic              clear,
`ifdef CURSOR_EN
  input  logic [6:0]        cursor_col,
  input  logic [5:0]        cursor_row,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              hsync,
  output logic              vsync,
  output logic              bright,
  output logic [7:0]        rgb,
  output logic [9:0]        hcount,
  output logic [9:0]        vcount,
  output logic              pix_en
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int COLS    = H_VIS / TILE_W;
  localparam int PH_W    = $clog2(PIX_DIV);

  typedef enum logic [1:0] {IDLE, MAP, GLY, DONE} fetch_state_t;

  logic [PH_W-1:0]   phase;
  logic [9:0]        h;
  logic [9:0]        v;
  logic [9:0]        fh;
  logic [9:0]        fv;
  logic              slot_start;
  logic              slot_end;
  logic              vis;
  logic              tgt_vis;
  logic [ADDR_W-1:0] map_addr;
  logic [ADDR_W-1:0] gly_addr;
  fetch_state_t      state;
  logic [9:0]        fv_p0;
  logic              vld_p0;
  logic [7:0]        fg_p1;
  logic              vld_p1;
  logic [TILE_W-1:0] pend_glyph_p2;
  logic [7:0]        pend_fg_p2;
  logic [TILE_W-1:0] shreg;
  logic [7:0]        shfg;
  logic [7:0]        base_color;
  logic [7:0]        pix_color;

  assign pix_en     = (phase == PH_W'(PIX_DIV - 1));
  assign slot_start = (int'(h) % TILE_W) == 0;
  assign slot_end   = (int'(h) % TILE_W) == TILE_W - 1;
  assign vis        = (h < 10'(H_VIS)) && (v < 10'(V_VIS));
  assign tgt_vis    = (fh < 10'(H_VIS)) && (fv < 10'(V_VIS));

  // Prefetch target: the tile one slot ahead, rolling onto the next line at the end of a line.
  always_comb begin
    fv = v;
    if (h >= 10'(H_TOTAL - TILE_W)) begin
      fh = h - 10'(H_TOTAL - TILE_W);
      fv = (v == 10'(V_TOTAL - 1)) ? 10'd0 : v + 10'd1;
    end else begin
      fh = h + 10'(TILE_W);
    end
  end

  always_comb begin
    map_addr = ADDR_W'(int'(MAP_BASE) + (int'(fv) / TILE_H) * COLS + int'(fh) / TILE_W);
    gly_addr = ADDR_W'(int'(GLYPH_BASE) + int'(mem_rdata[7:0]) * TILE_H + int'(fv_p0) % TILE_H);
  end

`ifdef CURSOR_EN
  logic [5:0] frame_cnt;
  logic       in_cursor;
  assign in_cursor = frame_cnt[5] && (int'(h) / TILE_W == int'(cursor_col))
                     && (int'(v) / TILE_H == int'(cursor_row));
`endif

  always_comb begin
    base_color = shreg[TILE_W-1] ? shfg : BG_COLOR;
`ifdef CURSOR_EN
    if (in_cursor) base_color = ~base_color;
`endif
    pix_color = vis ? base_color : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state         <= IDLE;
      mem_addr      <= '0;
      fv_p0         <= '0;
      vld_p0        <= 1'b0;
      fg_p1         <= '0;
      vld_p1        <= 1'b0;
      pend_glyph_p2 <= '0;
      pend_fg_p2    <= '0;
    end else begin
      case (state)
        // p0: map word address issued for the tile one slot ahead
        IDLE: if (pix_en && slot_start) begin
          mem_addr <= map_addr;
          fv_p0    <= fv;
          vld_p0   <= tgt_vis;
          state    <= MAP;
        end
        // p1: map word arrives; glyph row address follows from its index
        MAP: begin
          fg_p1    <= mem_rdata[15:8];
          vld_p1   <= vld_p0;
          mem_addr <= gly_addr;
          state    <= GLY;
        end
        // p2: glyph row arrives; off-screen targets park an empty row
        GLY: begin
          pend_glyph_p2 <= vld_p1 ? mem_rdata[TILE_W-1:0] : '0;
          pend_fg_p2    <= fg_p1;
          state         <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      phase  <= '0;
      h      <= '0;
      v      <= '0;
      hcount <= '0;
      vcount <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      bright <= 1'b0;
      rgb    <= '0;
      shreg  <= '0;
      shfg   <= '0;
`ifdef CURSOR_EN
      frame_cnt <= '0;
`endif
    end else begin
      phase <= pix_en ? '0 : phase + PH_W'(1);
      if (pix_en) begin
        // pins: registered view of the counter value in effect before this edge
        hcount <= h;
        vcount <= v;
        hsync  <= !((h >= 10'(H_VIS + H_FP)) && (h < 10'(H_VIS + H_FP + H_SYNC)));
        vsync  <= !((v >= 10'(V_VIS + V_FP)) && (v < 10'(V_VIS + V_FP + V_SYNC)));
        bright <= vis;
        rgb    <= pix_color;
        if (h == 10'(H_TOTAL - 1)) begin
          h <= '0;
          if (v == 10'(V_TOTAL - 1)) begin
            v <= '0;
`ifdef CURSOR_EN
            frame_cnt <= frame_cnt + 6'd1;
`endif
          end else begin
            v <= v + 10'd1;
          end
        end else begin
          h <= h + 10'd1;
        end
        if (slot_end) begin
          shreg <= pend_glyph_p2;
          shfg  <= pend_fg_p2;
        end else begin
          shreg <= shreg << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer: default-timing instance for line/address checks, small-raster instance for pixel checks.
module tb_vga_tile_renderer;

  localparam int PD_B = 3;
  localparam int HV = 32, HFP = 8, HS = 8, HBP = 16, HT = HV + HFP + HS + HBP;
  localparam int VV = 16, VFP = 2, VS = 2, VBP = 4, VT = VV + VFP + VS + VBP;
  localparam int TW = 8, TH = 8, COLS_B = HV / TW;
  localparam logic [7:0]  BG_B  = 8'h25;
  localparam logic [15:0] MAP_B = 16'h0100;
  localparam logic [15:0] GLY_B = 16'h2000;

  logic clk = 1'b0;
  logic clear = 1'b1;

  logic [15:0] addr_a, rdata_a, addr_b, rdata_b;
  logic        hs_a, vs_a, br_a, pe_a, hs_b, vs_b, br_b, pe_b;
  logic [7:0]  rgb_a, rgb_b;
  logic [9:0]  hc_a, vc_a, hc_b, vc_b;

  logic [15:0] ram [0:65535];
  // Each DUT registers its address; the word for that address is captured at the following edge.
  assign rdata_a = ram[addr_a];
  assign rdata_b = ram[addr_b];

  always #5 clk = ~clk;

  vga_tile_renderer dut_a (
    .clk(clk), .clear(clear),
`ifdef CURSOR_EN
    .cursor_col(7'd0), .cursor_row(6'd0),
`endif
    .mem_addr(addr_a), .mem_rdata(rdata_a), .hsync(hs_a), .vsync(vs_a), .bright(br_a),
    .rgb(rgb_a), .hcount(hc_a), .vcount(vc_a), .pix_en(pe_a)
  );

  vga_tile_renderer #(
    .PIX_DIV(PD_B), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .TILE_W(TW), .TILE_H(TH),
    .ADDR_W(16), .MAP_BASE(MAP_B), .GLYPH_BASE(GLY_B), .BG_COLOR(BG_B)
  ) dut_b (
    .clk(clk), .clear(clear),
`ifdef CURSOR_EN
    .cursor_col(7'd0), .cursor_row(6'd0),
`endif
    .mem_addr(addr_b), .mem_rdata(rdata_b), .hsync(hs_b), .vsync(vs_b), .bright(br_b),
    .rgb(rgb_b), .hcount(hc_b), .vcount(vc_b), .pix_en(pe_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  bit prev_pe = 1'b0;
  int cyc = 0;
  int k = 0;
  int frame_bright = 0;
  logic [7:0] cap [0:VT-1][0:HT-1];

  typedef struct {
    int         hc;
    int         vc;
    logic [7:0] rgb;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference colour straight from the tile map and glyph table in memory.
  function automatic logic [7:0] tile_color(input int hc, input int vc);
    logic [15:0] ma, ga, m, g;
    ma = 16'(int'(MAP_B) + (vc / TH) * COLS_B + hc / TW);
    m  = ram[ma];
    ga = 16'(int'(GLY_B) + int'(m[7:0]) * TH + vc % TH);
    g  = ram[ga];
    return g[TW - 1 - hc % TW] ? m[15:8] : BG_B;
  endfunction

  always @(negedge clk) begin : monitor
    int p, hc, vc, f;
    logic [7:0] col;
    logic br, hs, vs;
    if (mon_en) begin
      cyc++;
      chk("pix_en phase", 32'(pe_b), 32'((cyc % PD_B) == PD_B - 1));
      if (prev_pe) begin
        k++;
        p  = k - 1;
        hc = p % HT;
        vc = (p / HT) % VT;
        f  = p / (HT * VT);
        br = (hc < HV) && (vc < VV);
        hs = !((hc >= HV + HFP) && (hc < HV + HFP + HS));
        vs = !((vc >= VV + VFP) && (vc < VV + VFP + VS));
        if (!br) col = 8'h00;
        else if (f == 0 && vc == 0 && hc < TW) col = BG_B;
        else col = tile_color(hc, vc);
        chk($sformatf("pixel h=%0d v=%0d f=%0d {hc,vc,hs,vs,br,rgb}", hc, vc, f),
            32'({hc_b, vc_b, hs_b, vs_b, br_b, rgb_b}),
            32'({10'(hc), 10'(vc), hs, vs, br, col}));
        cap[vc][hc] = rgb_b;
        if (br_b) frame_bright++;
        if (hc == HT - 1 && vc == VT - 1) begin
          chk("bright pixels per frame", 32'(frame_bright), 32'(HV * VV));
          frame_bright = 0;
        end
      end
      prev_pe = pe_b;
    end
  end

  task automatic check_reset();
    chk("rst hcount_b", 32'(hc_b), 32'd0);
    chk("rst vcount_b", 32'(vc_b), 32'd0);
    chk("rst hsync_b", 32'(hs_b), 32'd1);
    chk("rst vsync_b", 32'(vs_b), 32'd1);
    chk("rst bright_b", 32'(br_b), 32'd0);
    chk("rst rgb_b", 32'(rgb_b), 32'd0);
    chk("rst mem_addr_b", 32'(addr_b), 32'd0);
    chk("rst pix_en_b", 32'(pe_b), 32'd0);
    chk("rst a {hc,vc,hs,vs,br,rgb,addr}", 32'({hc_a, vc_a, hs_a, vs_a, br_a}), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
    chk("rst a rgb/addr", 32'({rgb_a, addr_a}), 32'd0);
  endtask

  task automatic do_reset(input bit rand_ram);
    @(negedge clk);
    mon_en = 1'b0;
    clear  = 1'b1;
    if (rand_ram) begin
      for (int i = 0; i < COLS_B * (VV / TH); i++) ram[MAP_B + 16'(i)] = 16'($urandom);
      for (int i = 0; i < 256 * TH; i++) ram[GLY_B + 16'(i)] = 16'($urandom);
    end
    repeat (3) @(negedge clk);
    check_reset();
    clear = 1'b0;
    cyc = 0;
    k = 0;
    prev_pe = 1'b0;
    frame_bright = 0;
    @(posedge clk);
    #1 mon_en = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, m, tgt;
    logic [15:0] exp_g;

    for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
    ram[16'h0100] = 16'hE041; ram[16'h2208] = 16'h0081;
    ram[16'h0101] = 16'h0302; ram[16'h2017] = 16'hFF01;
    ram[16'h0107] = 16'h1C05; ram[16'h202B] = 16'h00F0;
    ram[16'h0151] = 16'h7A33;

    tbl[0]  = '{0, 0, 8'hE0};   tbl[1]  = '{1, 0, BG_B};   tbl[2]  = '{3, 0, BG_B};
    tbl[3]  = '{6, 0, BG_B};    tbl[4]  = '{7, 0, 8'hE0};  tbl[5]  = '{0, 1, BG_B};
    tbl[6]  = '{8, 7, BG_B};    tbl[7]  = '{15, 7, 8'h03}; tbl[8]  = '{24, 11, 8'h1C};
    tbl[9]  = '{27, 11, 8'h1C}; tbl[10] = '{28, 11, BG_B}; tbl[11] = '{35, 0, 8'h00};
    tbl[12] = '{0, 16, 8'h00};

    do_reset(1'b0);

    // Default 640x480 line timing on instance A.
    n = 0;
    while (hs_a !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    chk("A hsync falls", 32'(hs_a === 1'b0), 32'd1);
    chk("A hsync start hcount", 32'(hc_a), 32'd656);
    n = 0;
    do begin @(negedge clk); n++; end while (hs_a === 1'b0 && n < 400);
    chk("A hsync low clks", 32'(n), 32'd192);
    m = n;
    while (hs_a !== 1'b0 && m < 4000) begin @(negedge clk); m++; end
    chk("A line period clks", 32'(m), 32'd1600);

    n = 0;
    while (!(addr_a == 16'h0151 && vc_a == 10'd8) && n < 20000) begin @(negedge clk); n++; end
    chk("A map fetch on line 8", 32'(addr_a == 16'h0151 && vc_a == 10'd8), 32'd1);
    chk("A map fetch hcount", 32'(hc_a), 32'd0);
    exp_g = 16'h2000 + 16'(ram[16'h0151][7:0]) * 16'd8;
    @(negedge clk);
    chk("A glyph fetch addr", 32'(addr_a), 32'(exp_g));

    repeat (2 * HT * VT * PD_B) @(negedge clk);
    for (int i = 0; i < 13; i++)
      chk($sformatf("table %0d rgb at h=%0d v=%0d", i, tbl[i].hc, tbl[i].vc),
          32'(cap[tbl[i].vc][tbl[i].hc]), 32'(tbl[i].rgb));

    // Mid-line resets with fresh random tile maps and glyphs.
    for (int r = 0; r < 2; r++) begin
      tgt = $urandom_range(5, 28);
      n = 0;
      while (hc_b != 10'(tgt) && n < 2000) begin @(negedge clk); n++; end
      chk("mid-line reset point reached", 32'(hc_b == 10'(tgt)), 32'd1);
      do_reset(1'b1);
      repeat (2 * HT * VT * PD_B + 500) @(negedge clk);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
